copperv: RTL and testbench

- Multicycle, non-pipelined RV32I processor core; one instruction completes before the next fetch begins.
- Top-level CPU of the system, with three bus masters: instruction read (ir_*), data read (dr_*) and data write (dw_*).
- Each bus master uses independent valid/ready request and response channels, connected to the system crossbar.

---
 rtl/copperv.sv | 222 ++++++++++++++++++++++
 tb/tb_copperv.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/copperv.sv
// copperv: multicycle, non-pipelined RV32I core with separate instruction-read,
// data-read and data-write valid/ready bus masters.
//
// state      | meaning
// FETCH      | present PC on ir_addr until accepted
// INST       | wait for the instruction word
// EXEC       | decode, ALU/branch, write back or start a memory access
// LOAD_ADDR  | present load address until accepted
// LOAD_DATA  | wait for load word, extract/extend, write rd
// STORE      | present store address/data/strobe until accepted
// STORE_RESP | wait for write response (error code is ignored)
module copperv #(
    parameter logic [31:0] PC_INIT        = 32'h0,
    parameter int          BUS_WIDTH      = 32,
    parameter int          BUS_RESP_WIDTH = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      ir_addr_valid,
    input  logic                      ir_addr_ready,
    output logic [BUS_WIDTH-1:0]      ir_addr,
    input  logic                      ir_data_valid,
    output logic                      ir_data_ready,
    input  logic [BUS_WIDTH-1:0]      ir_data,
    output logic                      dr_addr_valid,
    input  logic                      dr_addr_ready,
    output logic [BUS_WIDTH-1:0]      dr_addr,
    input  logic                      dr_data_valid,
    output logic                      dr_data_ready,
    input  logic [BUS_WIDTH-1:0]      dr_data,
    output logic                      dw_data_addr_valid,
    input  logic                      dw_data_addr_ready,
    output logic [BUS_WIDTH-1:0]      dw_addr,
    output logic [BUS_WIDTH-1:0]      dw_data,
    output logic [BUS_WIDTH/8-1:0]    dw_strobe,
    input  logic                      dw_resp_valid,
    output logic                      dw_resp_ready,
    input  logic [BUS_RESP_WIDTH-1:0] dw_resp
);
    typedef enum logic [2:0] {
        FETCH, INST, EXEC, LOAD_ADDR, LOAD_DATA, STORE, STORE_RESP
    } state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] regs [32];

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [31:0] rs1_val, rs2_val, imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] op_b, alu_res, next_pc, wb_val, mem_addr, load_val, st_data;
    logic [4:0]  shamt;
    logic [3:0]  st_strb;
    logic        wb_en, take;
    logic [1:0]  off;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // decode, ALU, branch resolution and write-back selection for the latched instruction
    always_comb begin
        opcode  = instr[6:0];
        rd      = instr[11:7];
        funct3  = instr[14:12];
        rs1_val = regs[instr[19:15]];
        rs2_val = regs[instr[24:20]];
        imm_i   = {{20{instr[31]}}, instr[31:20]};
        imm_s   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        imm_b   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        imm_u   = {instr[31:12], 12'b0};
        imm_j   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        op_b    = (opcode == OP_REG) ? rs2_val : imm_i;
        shamt   = op_b[4:0];
        case (funct3)
            3'b000:  alu_res = (opcode == OP_REG && instr[30]) ? rs1_val - op_b : rs1_val + op_b;
            3'b001:  alu_res = rs1_val << shamt;
            3'b010:  alu_res = {31'b0, $signed(rs1_val) < $signed(op_b)};
            3'b011:  alu_res = {31'b0, rs1_val < op_b};
            3'b100:  alu_res = rs1_val ^ op_b;
            3'b101:  alu_res = instr[30] ? 32'($signed(rs1_val) >>> shamt) : rs1_val >> shamt;
            3'b110:  alu_res = rs1_val | op_b;
            default: alu_res = rs1_val & op_b;
        endcase
        case (funct3)
            3'b000:  take = (rs1_val == rs2_val);
            3'b001:  take = (rs1_val != rs2_val);
            3'b100:  take = ($signed(rs1_val) < $signed(rs2_val));
            3'b101:  take = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  take = (rs1_val < rs2_val);
            3'b111:  take = (rs1_val >= rs2_val);
            default: take = 1'b0;
        endcase
        next_pc = pc + 32'd4;
        wb_en   = 1'b0;
        wb_val  = alu_res;
        case (opcode)
            OP_LUI:    begin wb_en = 1'b1; wb_val = imm_u; end
            OP_AUIPC:  begin wb_en = 1'b1; wb_val = pc + imm_u; end
            OP_JAL:    begin wb_en = 1'b1; wb_val = pc + 32'd4; next_pc = pc + imm_j; end
            OP_JALR:   begin wb_en = 1'b1; wb_val = pc + 32'd4; next_pc = (rs1_val + imm_i) & ~32'd1; end
            OP_BRANCH: if (take) next_pc = pc + imm_b;
            OP_IMM, OP_REG: wb_en = 1'b1;
            default:   ;
        endcase
    end

    // byte-lane placement for stores and extraction/extension for loads
    always_comb begin
        mem_addr = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
        off      = mem_addr[1:0];
        ld_byte  = dr_data[8*off +: 8];
        ld_half  = off[1] ? dr_data[31:16] : dr_data[15:0];
        case (funct3)
            3'b000:  load_val = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  load_val = {{16{ld_half[15]}}, ld_half};
            3'b100:  load_val = {24'b0, ld_byte};
            3'b101:  load_val = {16'b0, ld_half};
            default: load_val = dr_data;
        endcase
        case (funct3)
            3'b000:  begin st_strb = 4'b0001 << off; st_data = {4{rs2_val[7:0]}}; end
            3'b001:  begin st_strb = off[1] ? 4'b1100 : 4'b0011; st_data = {2{rs2_val[15:0]}}; end
            default: begin st_strb = 4'b1111; st_data = rs2_val; end
        endcase
    end

    // sequencing FSM with registered bus outputs, PC and register file
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state              <= FETCH;
            pc                 <= PC_INIT;
            instr              <= '0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
            ir_addr_valid      <= 1'b0;
            ir_addr            <= '0;
            ir_data_ready      <= 1'b0;
            dr_addr_valid      <= 1'b0;
            dr_addr            <= '0;
            dr_data_ready      <= 1'b0;
            dw_data_addr_valid <= 1'b0;
            dw_addr            <= '0;
            dw_data            <= '0;
            dw_strobe          <= '0;
            dw_resp_ready      <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    // only the first fetch after reset arrives here without valid already set
                    if (!ir_addr_valid) begin
                        ir_addr_valid <= 1'b1;
                        ir_addr       <= pc;
                    end else if (ir_addr_ready) begin
                        ir_addr_valid <= 1'b0;
                        ir_data_ready <= 1'b1;
                        state         <= INST;
                    end
                end
                INST: if (ir_data_valid) begin
                    ir_data_ready <= 1'b0;
                    instr         <= ir_data;
                    state         <= EXEC;
                end
                EXEC: begin
                    if (opcode == OP_LOAD) begin
                        dr_addr_valid <= 1'b1;
                        dr_addr       <= {mem_addr[31:2], 2'b00};
                        state         <= LOAD_ADDR;
                    end else if (opcode == OP_STORE) begin
                        dw_data_addr_valid <= 1'b1;
                        dw_addr            <= {mem_addr[31:2], 2'b00};
                        dw_data            <= st_data;
                        dw_strobe          <= st_strb;
                        state              <= STORE;
                    end else begin
                        if (wb_en && rd != 5'd0) regs[rd] <= wb_val;
                        pc            <= next_pc;
                        ir_addr_valid <= 1'b1;
                        ir_addr       <= next_pc;
                        state         <= FETCH;
                    end
                end
                LOAD_ADDR: if (dr_addr_ready) begin
                    dr_addr_valid <= 1'b0;
                    dr_data_ready <= 1'b1;
                    state         <= LOAD_DATA;
                end
                LOAD_DATA: if (dr_data_valid) begin
                    if (rd != 5'd0) regs[rd] <= load_val;
                    dr_data_ready <= 1'b0;
                    pc            <= pc + 32'd4;
                    ir_addr_valid <= 1'b1;
                    ir_addr       <= pc + 32'd4;
                    state         <= FETCH;
                end
                STORE: if (dw_data_addr_ready) begin
                    dw_data_addr_valid <= 1'b0;
                    dw_resp_ready      <= 1'b1;
                    state              <= STORE_RESP;
                end
                STORE_RESP: if (dw_resp_valid) begin
                    dw_resp_ready <= 1'b0;
                    pc            <= pc + 32'd4;
                    ir_addr_valid <= 1'b1;
                    ir_addr       <= pc + 32'd4;
                    state         <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_copperv.sv
// tb_copperv: directed program run on the copperv core with a memory-backed
// bus responder (zero-wait and random-stall modes) plus a mid-load reset.
module tb_copperv;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ir_addr_valid, ir_addr_ready, ir_data_valid, ir_data_ready;
    logic [31:0] ir_addr, ir_data;
    logic        dr_addr_valid, dr_addr_ready, dr_data_valid, dr_data_ready;
    logic [31:0] dr_addr, dr_data;
    logic        dw_data_addr_valid, dw_data_addr_ready, dw_resp_valid, dw_resp_ready;
    logic [31:0] dw_addr, dw_data;
    logic [3:0]  dw_strobe;
    logic [0:0]  dw_resp;

    copperv #(.PC_INIT(32'h0), .BUS_WIDTH(32), .BUS_RESP_WIDTH(1)) dut (
        .clk(clk), .rst(rst),
        .ir_addr_valid(ir_addr_valid), .ir_addr_ready(ir_addr_ready), .ir_addr(ir_addr),
        .ir_data_valid(ir_data_valid), .ir_data_ready(ir_data_ready), .ir_data(ir_data),
        .dr_addr_valid(dr_addr_valid), .dr_addr_ready(dr_addr_ready), .dr_addr(dr_addr),
        .dr_data_valid(dr_data_valid), .dr_data_ready(dr_data_ready), .dr_data(dr_data),
        .dw_data_addr_valid(dw_data_addr_valid), .dw_data_addr_ready(dw_data_addr_ready),
        .dw_addr(dw_addr), .dw_data(dw_data), .dw_strobe(dw_strobe),
        .dw_resp_valid(dw_resp_valid), .dw_resp_ready(dw_resp_ready), .dw_resp(dw_resp)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cycle = 0;
    int p;
    int end_addr;
    logic [31:0] mem [0:16383];

    bit          rand_mode = 0;
    bit          hold_dr = 0;
    int          phase = 0;
    int          dly = 0;
    int          stab_err = 0;
    logic [31:0] cap_addr, cap_data;
    logic [3:0]  cap_strb;
    logic [31:0] f_addr[$];
    int          f_time[$];
    logic [31:0] st_addr[$], st_data[$];
    logic [3:0]  st_strb[$];

    localparam int IDLE = 0, IR_A = 1, IR_A_ACK = 2, IR_D = 3, IR_D_ACK = 4,
                   DR_A = 5, DR_A_ACK = 6, DR_D = 7, DR_D_ACK = 8,
                   DW = 9, DW_ACK = 10, DW_R = 11, DW_R_ACK = 12;

    initial forever begin
        @(posedge clk);
        cycle++;
    end

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input logic [6:0] op);
        logic [31:0] i, a, f, d;
        i = imm; a = rs1; f = f3; d = rd;
        return {i[11:0], a[4:0], f[2:0], d[4:0], op};
    endfunction
    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
        logic [31:0] s, b, a, f, d;
        s = f7; b = rs2; a = rs1; f = f3; d = rd;
        return {s[6:0], b[4:0], a[4:0], f[2:0], d[4:0], 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
        logic [31:0] i, b, a, f;
        i = imm; b = rs2; a = rs1; f = f3;
        return {i[11:5], b[4:0], a[4:0], f[2:0], i[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
        logic [31:0] i, b, a, f;
        i = imm; b = rs2; a = rs1; f = f3;
        return {i[12], i[10:5], b[4:0], a[4:0], f[2:0], i[4:1], i[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_u(input int imm, input int rd, input logic [6:0] op);
        logic [31:0] i, d;
        i = imm; d = rd;
        return {i[19:0], d[4:0], op};
    endfunction
    function automatic logic [31:0] enc_j(input int imm, input int rd);
        logic [31:0] i, d;
        i = imm; d = rd;
        return {i[20], i[10:1], i[11], i[19:12], d[4:0], 7'b1101111};
    endfunction

    task automatic emit(input logic [31:0] w);
        mem[p >> 2] = w;
        p += 4;
    endtask

    task automatic init_mem();
        for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
        p = 0;
        emit(enc_i(12'h75B, 0, 0, 1, 7'b0010011));      // 0   ADDI x1,x0,0x75B
        emit(enc_u(20'h75BD, 2, 7'b0110111));           // 4   LUI  x2,0x75BD
        emit(enc_i(-747, 2, 0, 2, 7'b0010011));         // 8   ADDI x2,x2,0xD15 (-747)
        emit(enc_u(8, 3, 7'b0110111));                  // 12  LUI  x3,8
        emit(enc_s(0, 2, 3, 2));                        // 16  SW   x2,0(x3)
        emit(enc_i(8'h41, 0, 0, 5, 7'b0010011));        // 20  ADDI x5,x0,0x41
        emit(enc_s(5, 5, 3, 0));                        // 24  SB   x5,5(x3)
        emit(enc_i(18, 3, 0, 6, 7'b0000011));           // 28  LB   x6,18(x3)
        emit(enc_i(18, 3, 4, 7, 7'b0000011));           // 32  LBU  x7,18(x3)
        emit(enc_i(22, 3, 1, 8, 7'b0000011));           // 36  LH   x8,22(x3)
        emit(enc_i(20, 3, 5, 9, 7'b0000011));           // 40  LHU  x9,20(x3)
        emit(enc_i(0, 3, 2, 4, 7'b0000011));            // 44  LW   x4,0(x3)
        emit(enc_i(10, 0, 0, 1, 7'b0010011));           // 48  ADDI x1,x0,10
        emit(enc_i(0, 0, 0, 10, 7'b0010011));           // 52  ADDI x10,x0,0
        emit(enc_i(-1, 1, 0, 1, 7'b0010011));           // 56  loop: ADDI x1,x1,-1
        emit(enc_i(1, 10, 0, 10, 7'b0010011));          // 60  ADDI x10,x10,1
        emit(enc_b(-8, 0, 1, 1));                       // 64  BNE  x1,x0,loop
        emit(enc_j(8, 11));                             // 68  JAL  x11,+8
        emit(enc_i(1, 0, 0, 12, 7'b0010011));           // 72  ADDI x12,x0,1 (skipped)
        emit(enc_i(5, 0, 0, 0, 7'b0010011));            // 76  ADDI x0,x0,5
        emit(enc_i(0, 0, 0, 13, 7'b0010011));           // 80  ADDI x13,x0,0
        emit(enc_u(20'h80000, 14, 7'b0110111));         // 84  LUI  x14,0x80000
        emit(enc_i(31, 0, 0, 15, 7'b0010011));          // 88  ADDI x15,x0,31
        emit(enc_r(7'h20, 15, 14, 5, 16));              // 92  SRA  x16,x14,x15
        emit(enc_i(1, 0, 0, 17, 7'b0010011));           // 96  ADDI x17,x0,1
        emit(enc_i(-1, 0, 0, 18, 7'b0010011));          // 100 ADDI x18,x0,-1
        emit(enc_r(0, 18, 17, 3, 19));                  // 104 SLTU x19,x17,x18
        emit(enc_r(0, 18, 17, 2, 20));                  // 108 SLT  x20,x17,x18
        emit(enc_r(0, 15, 14, 5, 21));                  // 112 SRL  x21,x14,x15
        emit(enc_r(7'h20, 18, 17, 0, 22));              // 116 SUB  x22,x17,x18
        emit(enc_i(133, 0, 0, 24, 7'b0010011));         // 120 ADDI x24,x0,133
        emit(enc_i(0, 24, 0, 23, 7'b1100111));          // 124 JALR x23,0(x24)
        emit(enc_i(2, 0, 0, 12, 7'b0010011));           // 128 ADDI x12,x0,2 (skipped)
        emit(enc_u(1, 25, 7'b0010111));                 // 132 AUIPC x25,1
        emit(enc_i(-1, 17, 3, 26, 7'b0010011));         // 136 SLTIU x26,x17,-1
        end_addr = p;
        emit(enc_j(0, 0));                              // 140 JAL x0,0
        mem[32'h8010 >> 2] = 32'h0080_0000;
        mem[32'h8014 >> 2] = 32'hABCD_1234;
    endtask

    function automatic int pick();
        return rand_mode ? int'($urandom_range(0, 5)) : 0;
    endfunction

    // bus responder: one channel at a time, ready/valid changes on negedges
    initial begin
        ir_addr_ready = 0; ir_data_valid = 0; ir_data = 0;
        dr_addr_ready = 0; dr_data_valid = 0; dr_data = 0;
        dw_data_addr_ready = 0; dw_resp_valid = 0; dw_resp = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                ir_addr_ready = 0; ir_data_valid = 0; dr_addr_ready = 0; dr_data_valid = 0;
                dw_data_addr_ready = 0; dw_resp_valid = 0; phase = IDLE; dly = 0;
                continue;
            end
            case (phase)
                IR_A_ACK: begin
                    ir_addr_ready = 0; f_addr.push_back(cap_addr); f_time.push_back(cycle);
                    dly = pick(); phase = IR_D;
                end
                IR_D_ACK: begin ir_data_valid = 0; phase = IDLE; end
                DR_A_ACK: begin dr_addr_ready = 0; dly = pick(); phase = DR_D; end
                DR_D_ACK: begin dr_data_valid = 0; phase = IDLE; end
                DW_ACK: begin
                    dw_data_addr_ready = 0;
                    for (int b = 0; b < 4; b++)
                        if (cap_strb[b]) mem[cap_addr[15:2]][8*b +: 8] = cap_data[8*b +: 8];
                    st_addr.push_back(cap_addr); st_data.push_back(cap_data); st_strb.push_back(cap_strb);
                    dly = pick(); phase = DW_R;
                end
                DW_R_ACK: begin dw_resp_valid = 0; phase = IDLE; end
                default: ;
            endcase
            if (phase == IDLE) begin
                if (ir_addr_valid) begin
                    cap_addr = ir_addr; dly = pick(); phase = IR_A;
                end else if (dr_addr_valid) begin
                    cap_addr = dr_addr; dly = pick(); phase = DR_A;
                end else if (dw_data_addr_valid) begin
                    cap_addr = dw_addr; cap_data = dw_data; cap_strb = dw_strobe;
                    dly = pick(); phase = DW;
                end
            end
            case (phase)
                IR_A: begin
                    if (!ir_addr_valid || ir_addr !== cap_addr) stab_err++;
                    if (dly == 0) begin ir_addr_ready = 1; phase = IR_A_ACK; end else dly--;
                end
                IR_D: begin
                    if (dly == 0) begin
                        ir_data_valid = 1; ir_data = mem[cap_addr[15:2]]; phase = IR_D_ACK;
                    end else dly--;
                end
                DR_A: begin
                    if (!dr_addr_valid || dr_addr !== cap_addr) stab_err++;
                    if (dly == 0) begin dr_addr_ready = 1; phase = DR_A_ACK; end else dly--;
                end
                DR_D: begin
                    if (dly > 0) dly--;
                    else if (!hold_dr) begin
                        dr_data_valid = 1; dr_data = mem[cap_addr[15:2]]; phase = DR_D_ACK;
                    end
                end
                DW: begin
                    if (!dw_data_addr_valid || dw_addr !== cap_addr || dw_data !== cap_data ||
                        dw_strobe !== cap_strb) stab_err++;
                    if (dly == 0) begin dw_data_addr_ready = 1; phase = DW_ACK; end else dly--;
                end
                DW_R: begin
                    if (dly == 0) begin dw_resp_valid = 1; dw_resp = 0; phase = DW_R_ACK; end else dly--;
                end
                default: ;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int fetch_gap(input logic [31:0] a);
        for (int i = 0; i + 1 < f_addr.size(); i++)
            if (f_addr[i] == a) return f_time[i+1] - f_time[i];
        return -1;
    endfunction

    task automatic run_prog(input bit rnd);
        bit done;
        init_mem();
        rand_mode = rnd; hold_dr = 0; stab_err = 0;
        f_addr.delete(); f_time.delete(); st_addr.delete(); st_data.delete(); st_strb.delete();
        rst = 0;
        repeat (3) @(negedge clk);
        rst = 1;
        done = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            if (ir_addr_valid && ir_addr == end_addr) done = 1;
        end
        chk("program_end_reached", {31'b0, done}, 32'd1);
    endtask

    task automatic check_arch(input string pfx);
        logic [31:0] t;
        chk({pfx, " x0"},  dut.regs[0],  32'h0);
        chk({pfx, " x1"},  dut.regs[1],  32'h0);
        chk({pfx, " x2"},  dut.regs[2],  32'd123456789);
        chk({pfx, " x3"},  dut.regs[3],  32'h8000);
        chk({pfx, " x4_lw"}, dut.regs[4], 32'd123456789);
        chk({pfx, " x6_lb"}, dut.regs[6], 32'hFFFF_FF80);
        chk({pfx, " x7_lbu"}, dut.regs[7], 32'h0000_0080);
        chk({pfx, " x8_lh"}, dut.regs[8], 32'hFFFF_ABCD);
        chk({pfx, " x9_lhu"}, dut.regs[9], 32'h0000_1234);
        chk({pfx, " x10_iters"}, dut.regs[10], 32'd10);
        chk({pfx, " x11_jal"}, dut.regs[11], 32'd72);
        chk({pfx, " x12_skipped"}, dut.regs[12], 32'h0);
        chk({pfx, " x13_x0_read"}, dut.regs[13], 32'h0);
        chk({pfx, " x16_sra"}, dut.regs[16], 32'hFFFF_FFFF);
        chk({pfx, " x19_sltu"}, dut.regs[19], 32'd1);
        chk({pfx, " x20_slt"}, dut.regs[20], 32'd0);
        chk({pfx, " x21_srl"}, dut.regs[21], 32'd1);
        chk({pfx, " x22_sub"}, dut.regs[22], 32'd2);
        chk({pfx, " x23_jalr"}, dut.regs[23], 32'd128);
        chk({pfx, " x25_auipc"}, dut.regs[25], 32'h1084);
        chk({pfx, " x26_sltiu"}, dut.regs[26], 32'd1);
        chk({pfx, " store_count"}, st_addr.size(), 32'd2);
        if (st_addr.size() == 2) begin
            chk({pfx, " sw_addr"}, st_addr[0], 32'h8000);
            chk({pfx, " sw_data"}, st_data[0], 32'd123456789);
            chk({pfx, " sw_strobe"}, {28'b0, st_strb[0]}, 32'hF);
            chk({pfx, " sb_addr"}, st_addr[1], 32'h8004);
            chk({pfx, " sb_strobe"}, {28'b0, st_strb[1]}, 32'h2);
            t = st_data[1];
            chk({pfx, " sb_lane"}, {24'b0, t[15:8]}, 32'h41);
        end
        chk({pfx, " mem_8004"}, mem[32'h8004 >> 2], 32'h0000_4100);
        chk({pfx, " payload_stable"}, stab_err, 32'd0);
    endtask

    initial begin
        bit seen;
        #1;
        chk("reset_valids", {26'b0, ir_addr_valid, ir_data_ready, dr_addr_valid, dr_data_ready,
                             dw_data_addr_valid, dw_resp_ready}, 32'h0);
        chk("reset_payload", ir_addr | dr_addr | dw_addr | dw_data | {28'b0, dw_strobe}, 32'h0);

        run_prog(1'b0);
        check_arch("zw");
        chk("first_fetch_addr", f_addr.size() > 0 ? f_addr[0] : 32'hFFFF_FFFF, 32'h0);
        chk("lat_addi", fetch_gap(32'd0), 32'd3);
        chk("lat_lui", fetch_gap(32'd4), 32'd3);
        chk("lat_sw", fetch_gap(32'd16), 32'd5);
        chk("lat_lb", fetch_gap(32'd28), 32'd5);
        chk("lat_bne_taken", fetch_gap(32'd64), 32'd3);
        chk("lat_jal", fetch_gap(32'd68), 32'd3);

        run_prog(1'b1);
        check_arch("rnd");

        // reset while the core waits in LOAD_DATA
        init_mem();
        rand_mode = 0; hold_dr = 1;
        rst = 0;
        repeat (2) @(negedge clk);
        rst = 1;
        seen = 0;
        for (int i = 0; i < 500 && !seen; i++) begin
            @(negedge clk);
            if (dr_data_ready) seen = 1;
        end
        chk("reached_load_data", {31'b0, seen}, 32'd1);
        chk("load_data_valid_low", {31'b0, dr_data_valid}, 32'd0);
        #2 rst = 0;
        #1;
        chk("midload_reset_valids", {26'b0, ir_addr_valid, ir_data_ready, dr_addr_valid, dr_data_ready,
                                     dw_data_addr_valid, dw_resp_ready}, 32'h0);
        chk("midload_reset_payload", ir_addr | dr_addr | dw_addr | dw_data | {28'b0, dw_strobe}, 32'h0);
        @(posedge clk); #1;
        chk("midload_next_cycle_valids", {26'b0, ir_addr_valid, ir_data_ready, dr_addr_valid, dr_data_ready,
                                          dw_data_addr_valid, dw_resp_ready}, 32'h0);
        chk("midload_x2_cleared", dut.regs[2], 32'h0);
        hold_dr = 0;
        @(negedge clk);
        rst = 1;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (ir_addr_valid) seen = 1;
        end
        chk("post_reset_fetch_seen", {31'b0, seen}, 32'd1);
        chk("post_reset_fetch_addr", ir_addr, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
